// File: rtl/load_ext_unit.sv
// Load lane extractor: selects a byte/half/word/dword lane, sign- or zero-extends it,
// and buffers results in a 2-entry skid FIFO. Optional alignment checking under LOAD_ALIGN_CHK_EN.
module load_ext_unit #(
   parameter  int DATA_W = 32,
   parameter  int TAG_W  = 5,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFF_W-1:0]  in_off,
   input  logic [1:0]        in_size,
   input  logic              in_signed,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   function automatic logic [OFF_W-1:0] lane_mask(input logic [1:0] sz);
      return OFF_W'((1 << sz) - 1);
   endfunction

   // Shift the lane to the top, then shift back arithmetically or logically to extend.
   function automatic logic [DATA_W-1:0] extend_lane(input logic [DATA_W-1:0] data,
                                                      input logic [OFF_W-1:0]  off,
                                                      input logic [1:0]        sz,
                                                      input logic              sgn);
      logic [OFF_W-1:0]         base;
      logic [DATA_W-1:0]        sh;
      logic signed [DATA_W-1:0] left;
      int unsigned              pad;
      base = off & ~lane_mask(sz);
      sh   = data >> {base, 3'b000};
      pad  = DATA_W - (8 << sz);
      left = sh << pad;
      if (sgn)
         return left >>> pad;
      return left >> pad;
   endfunction

   logic [1:0]        sz_eff;
   logic [DATA_W-1:0] ext_data_p0;
   logic              ext_err_p0;
   logic              push, pop;
   logic [1:0]        count;
   logic              wr_ptr, rd_ptr;
   logic [DATA_W-1:0] data_q [2];
   logic [TAG_W-1:0]  tag_q  [2];

   always_comb begin
      sz_eff = in_size;
      if (DATA_W == 32 && in_size == 2'd3)
         sz_eff = 2'd2;
      ext_data_p0 = extend_lane(in_data, in_off, sz_eff, in_signed);
      ext_err_p0  = 1'b0;
`ifdef LOAD_ALIGN_CHK_EN
      if (((in_off & lane_mask(sz_eff)) != '0) || (DATA_W == 32 && in_size == 2'd3)) begin
         ext_err_p0  = 1'b1;
         ext_data_p0 = '0;
      end
`endif
   end

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage: written at the push edge, no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr] <= ext_data_p0;
         tag_q[wr_ptr]  <= in_tag;
      end
   end

   assign out_data = out_valid ? data_q[rd_ptr] : '0;
   assign out_tag  = out_valid ? tag_q[rd_ptr]  : '0;

`ifdef LOAD_ALIGN_CHK_EN
   logic err_q [2];

   always_ff @(posedge clk) begin
      if (push)
         err_q[wr_ptr] <= ext_err_p0;
   end

   assign out_err = out_valid ? err_q[rd_ptr] : 1'b0;
`else
   logic unused_err;
   assign unused_err = ext_err_p0;
   assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_load_ext_unit.sv
// Directed bench for load_ext_unit: 32-bit instance for lanes/handshakes, 64-bit instance for wide lanes.
module tb_load_ext_unit;

`ifdef LOAD_ALIGN_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0, in_ready, in_signed = 1'b0;
   logic [31:0] in_data = '0;
   logic [1:0]  in_off = '0, in_size = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid, out_ready = 1'b0, out_err;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   logic        w_in_valid = 1'b0, w_in_ready, w_in_signed = 1'b0;
   logic [63:0] w_in_data = '0;
   logic [2:0]  w_in_off = '0;
   logic [1:0]  w_in_size = '0;
   logic [4:0]  w_in_tag = '0;
   logic        w_out_valid, w_out_ready = 1'b0, w_out_err;
   logic [63:0] w_out_data;
   logic [4:0]  w_out_tag;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   load_ext_unit #(.DATA_W(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_off(in_off),
      .in_size(in_size), .in_signed(in_signed), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_err(out_err)
   );

   load_ext_unit #(.DATA_W(64), .TAG_W(5)) dut64 (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_off(w_in_off),
      .in_size(w_in_size), .in_signed(w_in_signed), .in_tag(w_in_tag),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
      .out_tag(w_out_tag), .out_err(w_out_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run32(input string nm, input logic [31:0] d, input logic [1:0] off,
                        input logic [1:0] sz, input logic sg, input logic [4:0] tg,
                        input logic [31:0] exp_d, input logic exp_e);
      in_data = d; in_off = off; in_size = sz; in_signed = sg; in_tag = tg;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({nm, "_vld"}, 64'(out_valid), 64'd1);
      check({nm, "_data"}, 64'(out_data), 64'(exp_d));
      check({nm, "_tag"}, 64'(out_tag), 64'(tg));
      check({nm, "_err"}, 64'(out_err), 64'(exp_e));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({nm, "_pop"}, 64'(out_valid), 64'd0);
   endtask

   task automatic run64(input string nm, input logic [63:0] d, input logic [2:0] off,
                        input logic [1:0] sz, input logic sg, input logic [63:0] exp_d);
      w_in_data = d; w_in_off = off; w_in_size = sz; w_in_signed = sg; w_in_tag = 5'd9;
      w_in_valid = 1'b1; w_out_ready = 1'b0;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      check({nm, "_vld"}, 64'(w_out_valid), 64'd1);
      check({nm, "_data"}, w_out_data, exp_d);
      w_out_ready = 1'b1;
      @(posedge clk); #1;
      w_out_ready = 1'b0;
      check({nm, "_pop"}, 64'(w_out_valid), 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_vld",   64'(out_valid), 64'd0);
      check("rst_rdy",   64'(in_ready),  64'd1);
      check("rst_data",  64'(out_data),  64'd0);
      check("rst_tag",   64'(out_tag),   64'd0);
      check("rst_err",   64'(out_err),   64'd0);

      run32("sbyte",  32'h12345680, 2'd0, 2'd0, 1'b1, 5'd5,  32'hFFFFFF80, 1'b0);
      run32("uhalf",  32'hBEEF0000, 2'd2, 2'd1, 1'b0, 5'd6,  32'h0000BEEF, 1'b0);
      run32("shalf",  32'hBEEF0000, 2'd2, 2'd1, 1'b1, 5'd7,  32'hFFFFBEEF, 1'b0);
      run32("ubyte3", 32'hAB000000, 2'd3, 2'd0, 1'b0, 5'd8,  32'h000000AB, 1'b0);
      run32("sbyte1", 32'h00007F00, 2'd1, 2'd0, 1'b1, 5'd11, 32'h0000007F, 1'b0);
      run32("sword",  32'h80000001, 2'd0, 2'd2, 1'b1, 5'd12, 32'h80000001, 1'b0);
      run32("misal",  32'h1234ABCD, 2'd1, 2'd1, 1'b0, 5'd13, CHK ? 32'h0 : 32'h0000ABCD, CHK);
      run32("dw32",   32'h80000001, 2'd0, 2'd3, 1'b1, 5'd14, CHK ? 32'h0 : 32'h80000001, CHK);

      // Backpressure: three back-to-back requests with the consumer stalled.
      in_size = 2'd2; in_off = 2'd0; in_signed = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; in_tag = 5'd1; in_data = 32'hA0000001;
      @(posedge clk); #1;
      check("bp_rdy1", 64'(in_ready), 64'd1);
      check("bp_head1", 64'(out_tag), 64'd1);
      in_tag = 5'd2; in_data = 32'hA0000002;
      @(posedge clk); #1;
      check("bp_rdy2", 64'(in_ready), 64'd0);
      check("bp_head2", 64'(out_tag), 64'd1);
      in_tag = 5'd3; in_data = 32'hA0000003;
      @(posedge clk); #1;
      check("bp_rdy3", 64'(in_ready), 64'd0);
      check("bp_hold_tag", 64'(out_tag), 64'd1);
      check("bp_hold_data", 64'(out_data), 64'hA0000001);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_drain1", 64'(out_tag), 64'd2);
      check("bp_drain1_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_drain2", 64'(out_tag), 64'd3);
      check("bp_drain2_data", 64'(out_data), 64'hA0000003);
      check("bp_drain2_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      check("bp_empty", 64'(out_valid), 64'd0);

      // Streaming: push and pop every cycle.
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_tag = 5'(10 + i); in_data = 32'(i) << 8; in_size = 2'd1; in_off = 2'd0;
         @(posedge clk); #1;
         check("st_tag", 64'(out_tag), 64'(10 + i));
         check("st_data", 64'(out_data), 64'(32'(i) << 8));
         check("st_rdy", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("st_empty", 64'(out_valid), 64'd0);

      // Reset with two entries buffered.
      out_ready = 1'b0; in_valid = 1'b1; in_size = 2'd2; in_data = 32'h55AA55AA;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      check("pre_rst_full", 64'(in_ready), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_vld", 64'(out_valid), 64'd0);
      check("mid_rst_rdy", 64'(in_ready), 64'd1);
      check("mid_rst_data", 64'(out_data), 64'd0);
      @(posedge clk); #1;
      check("post_rst_vld", 64'(out_valid), 64'd0);

      run64("w_sword4", 64'h80000001_12345678, 3'd4, 2'd2, 1'b1, 64'hFFFFFFFF80000001);
      run64("w_uword4", 64'h80000001_12345678, 3'd4, 2'd2, 1'b0, 64'h0000000080000001);
      run64("w_dword",  64'h80000001_12345678, 3'd0, 2'd3, 1'b1, 64'h80000001_12345678);
      run64("w_sbyte7", 64'h80000000_00000000, 3'd7, 2'd0, 1'b1, 64'hFFFFFFFFFFFFFF80);
      run64("w_shalf6", 64'h7FFF0000_00000000, 3'd6, 2'd1, 1'b1, 64'h0000000000007FFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
